ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 76800, meaning frame-buffer words (320 x 240 RGB444).
REQ-002 SHALL have port pclk  input  1  camera pixel clock; sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port capture_en  input  1  arm capture; sampled at frame start only.
REQ-005 SHALL have port cam_vsync  input  1  camera VSYNC, high = vertical blanking.
REQ-006 SHALL have port cam_href  input  1  camera HREF, high = active line bytes.
REQ-007 SHALL have port cam_data  input  8  camera byte bus.
REQ-008 SHALL have port frame_addr  output  17  write address into frame buffer.
REQ-009 SHALL have port frame_pixel  output  16  write data {4'b0,R[3:0],G[3:0],B[3:0]}, the format the VGA reader consumes (bits 11:0).
REQ-010 SHALL have port frame_we  output  1  write strobe, one pclk per pixel.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of captured frame.
REQ-012 SHALL have port overflow  output  1  sticky: frame carried more than FB_DEPTH pixels.

Function
REQ-013 SHALL implement FSM IDLE -> WAIT_SOF -> CAPTURE -> IDLE.
REQ-014 IDLE: move to WAIT_SOF when capture_en=1 and cam_vsync=1 (mid-frame arming waits for next blanking).
REQ-015 WAIT_SOF: on cam_vsync falling edge go to CAPTURE; clear address, byte phase, line/column counters.
REQ-016 CAPTURE: on cam_vsync rising edge pulse frame_done one cycle, go to WAIT_SOF if capture_en=1 else IDLE.
REQ-017 Dropping capture_en inside CAPTURE SHALL NOT abort; current frame completes.
REQ-018 Byte phase SHALL toggle each pclk with cam_href=1 and reset to 0 whenever cam_href=0.
REQ-019 Phase 0 byte SHALL be latched as xxxxRRRR; on phase 1 byte GGGGBBBB, pixel = {4'b0, byte0[3:0], byte1}.
REQ-020 Write latency: frame_we, frame_pixel, frame_addr registered, valid the pclk after the phase-1 byte is sampled.
REQ-021 frame_addr SHALL increment by 1 after each write; first write of frame at address 0.
REQ-022 Writes at address >= FB_DEPTH SHALL be suppressed (frame_we=0), address held at FB_DEPTH, overflow set.
REQ-023 overflow SHALL clear only on reset or on entry to CAPTURE.
REQ-024 A line with odd byte count SHALL drop the dangling byte; no write.
REQ-025 frame_we SHALL be 0 in IDLE and WAIT_SOF.
REQ-026 Edge detection of cam_vsync/cam_href SHALL use one registered previous-value stage; inputs are pclk-synchronous.

Reset
REQ-027 rst_n low SHALL force: state IDLE, frame_addr 0, frame_pixel 0, frame_we 0, frame_done 0, overflow 0, phase 0, counters 0.
REQ-028 Reset released mid-frame SHALL wait in IDLE/WAIT_SOF for a full vsync pulse before any write.

Configuration
REQ-029 Macro CAPTURE_DECIMATE_EN SHALL select 2:1 decimation.
REQ-030 Defined: camera delivers 640x480; only pixels with even column and even line index (counted from 0 per frame/line) written; column counts pixels per href, line increments on href falling edge.
REQ-031 Undefined: camera delivers 320x240; every pixel written; column/line counters omitted.

Structure
REQ-032 Package capture_pkg SHALL hold FB_WIDTH=320, FB_HEIGHT=240, FB_DEPTH=76800, ADDR_W=17, PIX_W=16 and the FSM state typedef.
REQ-033 One sub-module, cap_edge_det (registered rise/fall detector), SHALL be instantiated for cam_vsync and cam_href.

Verification
REQ-034 Full QVGA frame, bytes 0x0A,0xBC per pixel -> 76800 writes, frame_pixel=0x0ABC, addresses 0..76799, one frame_done, overflow=0.
REQ-035 capture_en raised mid-frame -> zero writes that frame; next frame captured from address 0.
REQ-036 241 lines of 320 pixels -> 76800 writes, 320 suppressed, overflow=1, frame_addr held 76800; cleared at next frame start.
REQ-037 Line with 641 bytes -> 320 writes for that line, dangling byte ignored.
REQ-038 CAPTURE_DECIMATE_EN, 640x480 frame, pixel value = {line[3:0],col[7:0]} -> 76800 writes, address 1 holds col 2 line 0, address 320 holds col 0 line 2.
REQ-039 rst_n pulsed low at pixel 1000 -> outputs zero immediately; no write until after next full vsync pulse.

Source files
------------

// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared sizes and FSM state type for the OV7670 capture block
package capture_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 17;
  localparam int PIX_W     = 16;

  // Counter widths for the 640x480 decimating camera mode
  localparam int COL_W     = 10;
  localparam int LINE_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cap_edge_det.sv
// rtl/cap_edge_det.sv - rise/fall detector against one registered previous-value stage
module cap_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  // Remember last cycle's level; input is already synchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;
  assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB444 byte-pair capture into a linear frame buffer (optional CAPTURE_DECIMATE_EN)
module ov7670_capture
  import capture_pkg::ADDR_W, capture_pkg::PIX_W, capture_pkg::cap_state_e,
         capture_pkg::ST_IDLE, capture_pkg::ST_WAIT_SOF, capture_pkg::ST_CAPTURE;
#(
  parameter int FB_DEPTH = 76800
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [PIX_W-1:0]  frame_pixel,
  output logic              frame_we,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(FB_DEPTH);

  cap_state_e        state_q;
  logic              phase_q;
  logic [3:0]        red_q;
  logic [ADDR_W-1:0] frame_addr_q;
  logic [PIX_W-1:0]  frame_pixel_q;
  logic              frame_we_q;
  logic              frame_done_q;
  logic              overflow_q;

  logic              vs_rise;
  logic              vs_fall;
  logic              href_rise;
  logic              href_fall;
  logic              sof_d;
  logic              pix_sample_d;
  logic              keep_d;
  logic [ADDR_W-1:0] addr_eff_d;
  logic [PIX_W-1:0]  pixel_d;

  cap_edge_det u_vsync_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .sig_i  (cam_vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  cap_edge_det u_href_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .sig_i  (cam_href),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  assign sof_d        = (state_q == ST_WAIT_SOF) && vs_fall;
  assign pix_sample_d = cam_href && phase_q;
  assign pixel_d      = {4'h0, red_q, cam_data};
  // A write issued last cycle bumps the address this cycle, so look through it
  assign addr_eff_d   = frame_addr_q + ADDR_W'(frame_we_q);

`ifdef CAPTURE_DECIMATE_EN
  logic [capture_pkg::COL_W-1:0]  col_q;
  logic [capture_pkg::LINE_W-1:0] line_q;
  logic                           unused_edge;

  assign keep_d      = ~col_q[0] & ~line_q[0];
  assign unused_edge = href_rise;

  // Pixel column within the current line and line index within the frame
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      line_q <= '0;
    end else if (sof_d) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      if (!cam_href) begin
        col_q <= '0;
      end else if (pix_sample_d) begin
        col_q <= col_q + capture_pkg::COL_W'(1);
      end
      if (href_fall) begin
        line_q <= line_q + capture_pkg::LINE_W'(1);
      end
    end
  end
`else
  logic unused_edge;

  assign keep_d      = 1'b1;
  assign unused_edge = href_rise ^ href_fall;
`endif

  // Byte phase within a pixel pair; a line ending on phase 1 drops its dangling byte
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      red_q   <= 4'h0;
    end else if (sof_d || !cam_href) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      if (!phase_q) begin
        red_q <= cam_data[3:0];
      end
    end
  end

  // Frame FSM with registered write port, end-of-frame pulse and sticky overflow
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      frame_we_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture_en && cam_vsync) begin
            state_q <= ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          if (vs_fall) begin
            state_q      <= ST_CAPTURE;
            frame_addr_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (frame_we_q) begin
            frame_addr_q <= frame_addr_q + ADDR_W'(1);
          end
          if (vs_rise) begin
            frame_done_q <= 1'b1;
            state_q      <= capture_en ? ST_WAIT_SOF : ST_IDLE;
          end else if (pix_sample_d && keep_d) begin
            frame_pixel_q <= pixel_d;
            if (addr_eff_d < DEPTH_LIMIT) begin
              frame_we_q <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_addr  = frame_addr_q;
  assign frame_pixel = frame_pixel_q;
  assign frame_we    = frame_we_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - self-checking bench for ov7670_capture with a pixel-level reference model
module tb_ov7670_capture;

  localparam int DEPTH = 64;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [16:0] frame_addr;
  logic [15:0] frame_pixel;
  logic        frame_we;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int passes = 0;
  int frame_writes = 0;
  int frame_dones = 0;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] pix;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    int lines;
    int bpl;
    int exp_writes;
    bit exp_ovf;
  } vec_t;

  vec_t vec[5];

  ov7670_capture #(.FB_DEPTH(DEPTH)) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .capture_en  (capture_en),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_addr  (frame_addr),
    .frame_pixel (frame_pixel),
    .frame_we    (frame_we),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Which camera pixels land in the frame buffer
  function automatic bit kept(input int col, input int ln);
`ifdef CAPTURE_DECIMATE_EN
    return (col % 2 == 0) && (ln % 2 == 0);
`else
    return (col >= 0) && (ln >= 0);
`endif
  endfunction

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_addr"}, frame_addr, 0);
    chk({tag, "_pixel"}, frame_pixel, 0);
    chk({tag, "_we"}, frame_we, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  // Write-port scoreboard
  always @(negedge pclk) begin
    if (frame_done) frame_dones++;
    if (frame_we) begin
      frame_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", frame_addr, -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", frame_addr, mon_e.addr);
        chk("wr_pixel", frame_pixel, mon_e.pix);
      end
    end
  end

  // Drive one camera frame; the model queues every write the buffer should see
  task automatic run_frame(input string tag, input int lines, input int bpl, input bit cap_start,
                           input int en_line, input bit en_val, input int rst_line,
                           output int m_writes, output bit m_ovf);
    int cand;
    int col;
    bit cap;
    logic [7:0] b;
    logic [7:0] b0;
    cand = 0;
    cap = cap_start;
    b0 = 8'h00;
    frame_writes = 0;
    frame_dones = 0;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
    for (int ln = 0; ln < lines; ln++) begin
      col = 0;
      for (int k = 0; k < bpl; k++) begin
        b = 8'($urandom);
        cam_href = 1'b1;
        cam_data = b;
        if (k % 2 == 0) begin
          b0 = b;
        end else begin
          if (cap && kept(col, ln)) begin
            if (cand < DEPTH) exp_q.push_back({17'(cand), {4'h0, b0[3:0], b}});
            cand++;
          end
          col++;
        end
        tick();
      end
      cam_href = 1'b0;
      cam_data = 8'($urandom);
      repeat ($urandom_range(1, 4)) tick();
      if (ln == en_line) capture_en = en_val;
      if (ln == rst_line) begin
        chk({tag, "_pre_rst_ovf"}, overflow, (cand > DEPTH) ? 1 : 0);
        rst_n = 1'b0;
        #1;
        reset_outputs_zero({tag, "_async"});
        tick();
        tick();
        rst_n = 1'b1;
        cap = 1'b0;
      end
    end
    cam_vsync = 1'b1;
    repeat (3) tick();
    m_writes = (cand > DEPTH) ? DEPTH : cand;
    m_ovf = (cand > DEPTH);
    chk({tag, "_writes"}, frame_writes, m_writes);
    chk({tag, "_dones"}, frame_dones, cap ? 1 : 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    if (cap) begin
      chk({tag, "_ovf"}, overflow, m_ovf);
      chk({tag, "_end_addr"}, frame_addr, m_writes);
    end
    exp_q.delete();
  endtask

  initial begin
    int mw;
    bit mo;
`ifdef CAPTURE_DECIMATE_EN
    vec[0] = '{16, 32, 64, 1'b0};
    vec[1] = '{18, 32, 64, 1'b1};
    vec[2] = '{4, 33, 16, 1'b0};
    vec[3] = '{3, 2, 2, 1'b0};
    vec[4] = '{0, 0, 0, 1'b0};
`else
    vec[0] = '{8, 16, 64, 1'b0};
    vec[1] = '{9, 16, 64, 1'b1};
    vec[2] = '{4, 17, 32, 1'b0};
    vec[3] = '{3, 2, 3, 1'b0};
    vec[4] = '{0, 0, 0, 1'b0};
`endif

    rst_n = 1'b0;
    repeat (3) tick();
    reset_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    capture_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("tbl%0d", i), vec[i].lines, vec[i].bpl, 1'b1, -1, 1'b0, -1, mw, mo);
      chk($sformatf("tbl%0d_const_writes", i), frame_writes, vec[i].exp_writes);
      chk($sformatf("tbl%0d_const_ovf", i), overflow, vec[i].exp_ovf);
      chk($sformatf("tbl%0d_const_addr", i), frame_addr, vec[i].exp_writes);
    end

    run_frame("drop_en", 4, 16, 1'b1, 0, 1'b0, -1, mw, mo);
    run_frame("mid_arm", 4, 16, 1'b0, 1, 1'b1, -1, mw, mo);
    run_frame("after_arm", 4, 16, 1'b1, -1, 1'b0, -1, mw, mo);

    run_frame("rst_mid", 10, 16, 1'b1, -1, 1'b0, 8, mw, mo);
    run_frame("post_rst", 3, 16, 1'b1, -1, 1'b0, -1, mw, mo);

    for (int r = 0; r < 6; r++) begin
      run_frame($sformatf("rnd%0d", r), $urandom_range(0, 12), $urandom_range(0, 21),
                1'b1, -1, 1'b0, -1, mw, mo);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
